// File: rtl/s1_wb_decoder.sv
// ============================================================================
// Module      : s1_wb_decoder
// Description : Wishbone address decoder / response mux, S1 core -> ROM/RAM.
//               Unmapped or hung accesses get a one-cycle error ack.
//               Optional statistics counters: S1_WB_DECODER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s1_wb_decoder #(
   parameter int                  ADDR_W   = 40,
   parameter int                  DATA_W   = 64,
   parameter logic [ADDR_W-13:0]  ROM_BASE = 28'hFFF0000,
   parameter logic [ADDR_W-17:0]  RAM_BASE = 24'h000004,
   parameter int                  TIMEOUT  = 16,
   parameter logic [DATA_W-1:0]   ERR_DATA = 64'h0100000001000000
) (
   input  logic              sys_clock_i,
   input  logic              sys_reset_i,
   input  logic              wbs_cycle_i,
   input  logic              wbs_strobe_i,
   input  logic [ADDR_W-1:0] wbs_addr_i,
   output logic [DATA_W-1:0] wbs_data_o,
   output logic              wbs_ack_o,
   output logic              wbs_err_o,
   output logic              rom_cycle_o,
   output logic              rom_strobe_o,
   input  logic [DATA_W-1:0] rom_data_i,
   input  logic              rom_ack_i,
   output logic              ram_cycle_o,
   output logic              ram_strobe_o,
   input  logic [DATA_W-1:0] ram_data_i,
   input  logic              ram_ack_i
`ifdef S1_WB_DECODER_STATS_EN
   ,
   output logic [31:0]       stat_xfer_o,
   output logic [15:0]       stat_err_o
`endif
);

   localparam int c_TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // Last BUSY cycle is the one in which the timer holds TIMEOUT-2.
   localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ERR  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ROM  = 2'd1,
      SEL_RAM  = 2'd2
   } sel_t;

   state_t          state_q, state_d;
   sel_t            sel_q, sel_d;
   logic [c_TW-1:0] timer_q, timer_d;

   logic w_rom_hit;
   logic w_ram_hit;
   logic w_slv_ack;
   logic w_unused;

   assign w_rom_hit = (wbs_addr_i[ADDR_W-1:12] == ROM_BASE);
   assign w_ram_hit = (wbs_addr_i[ADDR_W-1:16] == RAM_BASE);
   assign w_unused  = ^wbs_addr_i[11:0];

   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         state_q <= S_IDLE;
         sel_q   <= SEL_NONE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      timer_d      = timer_q;
      w_slv_ack    = 1'b0;
      wbs_data_o   = '0;
      wbs_ack_o    = 1'b0;
      wbs_err_o    = 1'b0;
      rom_cycle_o  = 1'b0;
      rom_strobe_o = 1'b0;
      ram_cycle_o  = 1'b0;
      ram_strobe_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (wbs_cycle_i && wbs_strobe_i) begin
               timer_d = '0;
               // ROM wins an overlapping match.
               if (w_rom_hit) begin
                  sel_d   = SEL_ROM;
                  state_d = S_BUSY;
               end else if (w_ram_hit) begin
                  sel_d   = SEL_RAM;
                  state_d = S_BUSY;
               end else begin
                  sel_d   = SEL_NONE;
                  state_d = S_ERR;
               end
            end
         end

         S_BUSY: begin
            if (!wbs_cycle_i) begin
               state_d = S_IDLE;
            end else begin
               case (sel_q)
                  SEL_ROM: begin
                     rom_cycle_o  = wbs_cycle_i;
                     rom_strobe_o = wbs_strobe_i;
                     w_slv_ack    = rom_ack_i;
                     wbs_data_o   = rom_data_i;
                  end
                  SEL_RAM: begin
                     ram_cycle_o  = wbs_cycle_i;
                     ram_strobe_o = wbs_strobe_i;
                     w_slv_ack    = ram_ack_i;
                     wbs_data_o   = ram_data_i;
                  end
                  default: w_slv_ack = 1'b0;
               endcase
               wbs_ack_o = w_slv_ack;
               if (w_slv_ack) begin
                  state_d = S_IDLE;
               end else if (timer_q == c_TLAST) begin
                  state_d = S_ERR;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end

         S_ERR: begin
            state_d = S_IDLE;
            if (wbs_cycle_i) begin
               wbs_ack_o  = 1'b1;
               wbs_err_o  = 1'b1;
               wbs_data_o = ERR_DATA;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

`ifdef S1_WB_DECODER_STATS_EN
   logic [31:0] stat_xfer_q;
   logic [15:0] stat_err_q;

   always_ff @(posedge sys_clock_i) begin
      if (sys_reset_i) begin
         stat_xfer_q <= '0;
         stat_err_q  <= '0;
      end else begin
         if ((state_q == S_BUSY) && wbs_ack_o && (stat_xfer_q != '1)) begin
            stat_xfer_q <= stat_xfer_q + 32'd1;
         end
         if ((state_q == S_ERR) && wbs_ack_o && (stat_err_q != '1)) begin
            stat_err_q <= stat_err_q + 16'd1;
         end
      end
   end

   assign stat_xfer_o = stat_xfer_q;
   assign stat_err_o  = stat_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_s1_wb_decoder.sv
// ============================================================================
// Module      : tb_s1_wb_decoder
// Description : Scoreboard bench for s1_wb_decoder with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_s1_wb_decoder;

   localparam logic [63:0] c_ERR_DATA = 64'h0100000001000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb;
   logic [39:0] addr;
   logic [63:0] wbs_data_o;
   logic        wbs_ack_o, wbs_err_o;
   logic        rom_cycle_o, rom_strobe_o, ram_cycle_o, ram_strobe_o;
   logic [63:0] rom_data, ram_data;
   logic        rom_ack, ram_ack;
`ifdef S1_WB_DECODER_STATS_EN
   logic [31:0] stat_xfer_o;
   logic [15:0] stat_err_o;
`endif

   typedef struct packed {
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   s1_wb_decoder dut (
      .sys_clock_i  (clk),
      .sys_reset_i  (rst),
      .wbs_cycle_i  (cyc),
      .wbs_strobe_i (stb),
      .wbs_addr_i   (addr),
      .wbs_data_o   (wbs_data_o),
      .wbs_ack_o    (wbs_ack_o),
      .wbs_err_o    (wbs_err_o),
      .rom_cycle_o  (rom_cycle_o),
      .rom_strobe_o (rom_strobe_o),
      .rom_data_i   (rom_data),
      .rom_ack_i    (rom_ack),
      .ram_cycle_o  (ram_cycle_o),
      .ram_strobe_o (ram_strobe_o),
      .ram_data_i   (ram_data),
      .ram_ack_i    (ram_ack)
`ifdef S1_WB_DECODER_STATS_EN
      ,
      .stat_xfer_o  (stat_xfer_o),
      .stat_err_o   (stat_err_o)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ack the DUT presents is matched against the scoreboard.
   always @(negedge clk) begin
      if (!rst && wbs_ack_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: data %h err %b with nothing expected", wbs_data_o, wbs_err_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (wbs_data_o !== mon_e.data || wbs_err_o !== mon_e.err) begin
               errors++;
               $display("FAIL ack_resp: got data %h err %b expected data %h err %b",
                        wbs_data_o, wbs_err_o, mon_e.data, mon_e.err);
            end
         end
      end
      if (wbs_ack_o !== 1'b1 && wbs_err_o === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL err_without_ack: err 1 ack %b", wbs_ack_o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // slave: 0 ROM, 1 RAM, 2 unmapped. lat = BUSY cycles before the slave acks.
   task automatic xfer(input logic [39:0] a, input int slave, input int lat, input logic [63:0] d);
      cyc  = 1'b1;
      stb  = 1'b1;
      addr = a;
      if (slave == 2) begin
         exp_q.push_back({c_ERR_DATA, 1'b1});
         step();
         chk("err_no_rom_stb", {63'd0, rom_strobe_o}, 64'd0);
         chk("err_no_ram_stb", {63'd0, ram_strobe_o}, 64'd0);
         step();
      end else begin
         rom_data = (slave == 0) ? d : ~d;
         ram_data = (slave == 1) ? d : ~d;
         step();
         chk("rom_cycle", {63'd0, rom_cycle_o},  {63'd0, slave == 0});
         chk("ram_strobe", {63'd0, ram_strobe_o}, {63'd0, slave == 1});
         repeat (lat) step();
         if (slave == 0) rom_ack = 1'b1;
         else            ram_ack = 1'b1;
         exp_q.push_back({d, 1'b0});
         step();
         rom_ack = 1'b0;
         ram_ack = 1'b0;
      end
      cyc = 1'b0;
      stb = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; addr = '0;
      rom_data = '0; ram_data = '0; rom_ack = 1'b0; ram_ack = 1'b0;
      repeat (3) step();
      chk("rst_ack",  {63'd0, wbs_ack_o}, 64'd0);
      chk("rst_data", wbs_data_o, 64'd0);
      chk("rst_stb",  {60'd0, rom_cycle_o, rom_strobe_o, ram_cycle_o, ram_strobe_o}, 64'd0);
      rst = 1'b0;
      step();

      xfer(40'hFF_F000_0008, 0, 1,  64'h1111_2222_3333_4444);
      xfer(40'h00_0004_0010, 1, 1,  64'hA5A5_0000_FFFF_5A5A);
      xfer(40'h00_0010_0000, 2, 0,  64'd0);
      xfer(40'hFF_F000_0FF8, 0, 3,  64'hDEAD_BEEF_0000_0001);
      xfer(40'h00_0004_FFF8, 1, 0,  64'h0123_4567_89AB_CDEF);
      xfer(40'hFF_F000_1000, 2, 0,  64'd0);
      xfer(40'h00_0005_0000, 2, 0,  64'd0);
      xfer(40'h00_0003_FFF8, 2, 0,  64'd0);
      // Ack in the final BUSY cycle beats the timeout.
      xfer(40'h00_0004_0100, 1, 14, 64'hCAFE_F00D_1234_5678);

      // Hung RAM: 15 BUSY cycles, then the error ack; a late ack is dropped.
      cyc = 1'b1; stb = 1'b1; addr = 40'h00_0004_0200;
      exp_q.push_back({c_ERR_DATA, 1'b1});
      repeat (15) step();
      chk("to_stb_last_busy", {63'd0, ram_strobe_o}, 64'd1);
      step();
      chk("to_stb_dropped", {63'd0, ram_strobe_o}, 64'd0);
      chk("to_err_ack",     {62'd0, wbs_ack_o, wbs_err_o}, 64'd3);
      step();
      cyc = 1'b0; stb = 1'b0; ram_ack = 1'b1;
      #1;
      chk("late_ack_ignored", {63'd0, wbs_ack_o}, 64'd0);
      step();
      ram_ack = 1'b0;

      // Master abort in the third BUSY cycle, with a coincident slave ack.
      cyc = 1'b1; stb = 1'b1; addr = 40'h00_0004_0300;
      repeat (3) step();
      cyc = 1'b0; stb = 1'b0; ram_ack = 1'b1;
      #1;
      chk("abort_gated", {61'd0, ram_cycle_o, ram_strobe_o, wbs_ack_o}, 64'd0);
      step();
      ram_ack = 1'b0;
      xfer(40'h00_0004_0400, 1, 2, 64'h5555_6666_7777_8888);

      // Reset mid-BUSY discards the transfer.
      cyc = 1'b1; stb = 1'b1; addr = 40'hFF_F000_0040;
      step();
      chk("pre_rst_stb", {63'd0, rom_strobe_o}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      #1;
      chk("post_rst_stb", {62'd0, rom_cycle_o, rom_strobe_o}, 64'd0);
      step();
      xfer(40'hFF_F000_0080, 0, 0, 64'h9999_AAAA_BBBB_CCCC);

`ifdef S1_WB_DECODER_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      xfer(40'hFF_F000_0000, 0, 0, 64'd1);
      xfer(40'h00_0010_0000, 2, 0, 64'd0);
      xfer(40'h00_0004_0000, 1, 1, 64'd2);
      xfer(40'h00_0000_0000, 2, 0, 64'd0);
      xfer(40'hFF_F000_0010, 0, 2, 64'd3);
      step();
      chk("stat_xfer", {32'd0, stat_xfer_o}, 64'd3);
      chk("stat_err",  {48'd0, stat_err_o},  64'd2);
`endif

      repeat (2) step();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
